// File: rtl/xbar_arb2.sv
// xbar_arb2: two-master TileLink-UL Channel A arbiter with Channel D return routing.
// Ports:
//   clk, reset (synchronous, active-low)
//   m{0,1}_a_*   : master Channel A requests (valid/ready handshake + header/payload)
//   a_*_out      : granted Channel A beat toward the crossbar; a_source_out = master index
//   d_*_in       : crossbar Channel D response; d_source_in selects the destination master
//   m{0,1}_d_*   : per-master D valid/ready; m_d_* is the shared D payload
//   err_unexp_d  : sticky flag, a D response reached a master with nothing outstanding
module xbar_arb2 #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned SIZE_WIDTH   = 3,
    parameter int unsigned OPCODE_WIDTH = 3,
    parameter int unsigned PARAM_WIDTH  = 3,
    parameter int unsigned SINK_WIDTH   = 1,
    parameter int unsigned MAX_OUTST    = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    m0_a_valid,
    output logic                    m0_a_ready,
    input  logic [OPCODE_WIDTH-1:0] m0_a_opcode,
    input  logic [PARAM_WIDTH-1:0]  m0_a_param,
    input  logic [SIZE_WIDTH-1:0]   m0_a_size,
    input  logic [ADDR_WIDTH-1:0]   m0_a_address,
    input  logic [MASK_WIDTH-1:0]   m0_a_mask,
    input  logic [DATA_WIDTH-1:0]   m0_a_data,

    input  logic                    m1_a_valid,
    output logic                    m1_a_ready,
    input  logic [OPCODE_WIDTH-1:0] m1_a_opcode,
    input  logic [PARAM_WIDTH-1:0]  m1_a_param,
    input  logic [SIZE_WIDTH-1:0]   m1_a_size,
    input  logic [ADDR_WIDTH-1:0]   m1_a_address,
    input  logic [MASK_WIDTH-1:0]   m1_a_mask,
    input  logic [DATA_WIDTH-1:0]   m1_a_data,

    output logic                    a_valid_out,
    input  logic                    a_ready_out,
    output logic [OPCODE_WIDTH-1:0] a_opcode_out,
    output logic [PARAM_WIDTH-1:0]  a_param_out,
    output logic [SIZE_WIDTH-1:0]   a_size_out,
    output logic [ADDR_WIDTH-1:0]   a_address_out,
    output logic [MASK_WIDTH-1:0]   a_mask_out,
    output logic [DATA_WIDTH-1:0]   a_data_out,
    output logic                    a_source_out,

    input  logic                    d_valid_in,
    output logic                    d_ready_in,
    input  logic [OPCODE_WIDTH-1:0] d_opcode_in,
    input  logic [PARAM_WIDTH-1:0]  d_param_in,
    input  logic [SIZE_WIDTH-1:0]   d_size_in,
    input  logic [SINK_WIDTH-1:0]   d_sink_in,
    input  logic [DATA_WIDTH-1:0]   d_data_in,
    input  logic                    d_error_in,
    input  logic                    d_source_in,

    output logic                    m0_d_valid,
    output logic                    m1_d_valid,
    input  logic                    m0_d_ready,
    input  logic                    m1_d_ready,
    output logic [OPCODE_WIDTH-1:0] m_d_opcode,
    output logic [PARAM_WIDTH-1:0]  m_d_param,
    output logic [SIZE_WIDTH-1:0]   m_d_size,
    output logic [SINK_WIDTH-1:0]   m_d_sink,
    output logic [DATA_WIDTH-1:0]   m_d_data,
    output logic                    m_d_error,

    output logic                    err_unexp_d
);

    localparam int unsigned CW = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            rr_pri, rr_pri_nxt;
    logic [CW-1:0]   cnt0, cnt1, cnt0_nxt, cnt1_nxt;
    logic            elig0, elig1;
    logic            hs0, hs1;
    logic            dfire0, dfire1;
    logic            err_nxt;

    // Eligibility gates the grant, so a counter can never pass MAX_OUTST.
    assign elig0 = m0_a_valid && (cnt0 < CW'(MAX_OUTST));
    assign elig1 = m1_a_valid && (cnt1 < CW'(MAX_OUTST));

    assign hs0 = (state == GNT0) && m0_a_valid && a_ready_out;
    assign hs1 = (state == GNT1) && m1_a_valid && a_ready_out;

    // Channel D return path: purely combinational steering by source index.
    assign m0_d_valid = d_valid_in && !d_source_in;
    assign m1_d_valid = d_valid_in &&  d_source_in;
    assign d_ready_in = d_source_in ? m1_d_ready : m0_d_ready;
    assign m_d_opcode = d_opcode_in;
    assign m_d_param  = d_param_in;
    assign m_d_size   = d_size_in;
    assign m_d_sink   = d_sink_in;
    assign m_d_data   = d_data_in;
    assign m_d_error  = d_error_in;

    assign dfire0 = d_valid_in && d_ready_in && !d_source_in;
    assign dfire1 = d_valid_in && d_ready_in &&  d_source_in;

    // State, priority, outstanding counters and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            rr_pri      <= 1'b0;
            cnt0        <= '0;
            cnt1        <= '0;
            err_unexp_d <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_pri      <= rr_pri_nxt;
            cnt0        <= cnt0_nxt;
            cnt1        <= cnt1_nxt;
            err_unexp_d <= err_nxt;
        end
    end

    // Next-state and granted-port muxing; the grant holds until the beat is taken or withdrawn.
    always_comb begin
        state_nxt     = state;
        rr_pri_nxt    = rr_pri;
        a_valid_out   = 1'b0;
        m0_a_ready    = 1'b0;
        m1_a_ready    = 1'b0;
        a_source_out  = 1'b0;
        a_opcode_out  = '0;
        a_param_out   = '0;
        a_size_out    = '0;
        a_address_out = '0;
        a_mask_out    = '0;
        a_data_out    = '0;
        case (state)
            IDLE: begin
                if (elig0 && elig1) state_nxt = rr_pri ? GNT1 : GNT0;
                else if (elig0)     state_nxt = GNT0;
                else if (elig1)     state_nxt = GNT1;
            end
            GNT0: begin
                a_valid_out   = m0_a_valid;
                m0_a_ready    = a_ready_out;
                a_opcode_out  = m0_a_opcode;
                a_param_out   = m0_a_param;
                a_size_out    = m0_a_size;
                a_address_out = m0_a_address;
                a_mask_out    = m0_a_mask;
                a_data_out    = m0_a_data;
                if (hs0) begin
                    state_nxt  = IDLE;
                    rr_pri_nxt = 1'b1;
                end else if (!m0_a_valid) begin
                    state_nxt  = IDLE;
                end
            end
            GNT1: begin
                a_valid_out   = m1_a_valid;
                m1_a_ready    = a_ready_out;
                a_source_out  = 1'b1;
                a_opcode_out  = m1_a_opcode;
                a_param_out   = m1_a_param;
                a_size_out    = m1_a_size;
                a_address_out = m1_a_address;
                a_mask_out    = m1_a_mask;
                a_data_out    = m1_a_data;
                if (hs1) begin
                    state_nxt  = IDLE;
                    rr_pri_nxt = 1'b0;
                end else if (!m1_a_valid) begin
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outstanding counters: a same-cycle request and response cancel; no underflow.
    always_comb begin
        cnt0_nxt = cnt0;
        cnt1_nxt = cnt1;
        err_nxt  = err_unexp_d;
        if (hs0 && !dfire0)                      cnt0_nxt = cnt0 + CW'(1);
        else if (!hs0 && dfire0 && cnt0 != '0)   cnt0_nxt = cnt0 - CW'(1);
        if (hs1 && !dfire1)                      cnt1_nxt = cnt1 + CW'(1);
        else if (!hs1 && dfire1 && cnt1 != '0)   cnt1_nxt = cnt1 - CW'(1);
        if ((dfire0 && cnt0 == '0) || (dfire1 && cnt1 == '0)) err_nxt = 1'b1;
    end

endmodule

// File: doc/xbar_arb2.md
Name: xbar_arb2

Overview:
- Two-master TileLink-UL arbiter in front of the single-master crossbar path; the crossbar's Channel A inputs and Channel D outputs connect directly to this block.
- Round-robin, per-beat arbitration of master Channel A requests onto one downstream A port.
- Tags each accepted request with the master index in `a_source_out`.
- Routes Channel D responses back by `d_source_in` and enforces a per-master outstanding-request limit.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width
- SIZE_WIDTH, 3, size field width
- OPCODE_WIDTH, 3, opcode width
- PARAM_WIDTH, 3, param width
- MAX_OUTST, 4, max in-flight requests per master (1..15); counter width CW = clog2(MAX_OUTST+1)

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- m0_a_valid / m1_a_valid  input  1 each  master A valid
- m0_a_ready / m1_a_ready  output  1 each  master A ready
- m{0,1}_a_opcode, _param, _size  input  OPCODE/PARAM/SIZE_WIDTH  master A header
- m{0,1}_a_address, _mask, _data  input  ADDR/MASK/DATA_WIDTH  master A payload
- a_valid_out  output  1  downstream A valid
- a_ready_out  input  1  downstream A ready
- a_opcode_out, a_param_out, a_size_out, a_address_out, a_mask_out, a_data_out  output  as above  granted payload
- a_source_out  output  1  granted master index
- d_valid_in  input  1  downstream D valid
- d_ready_in  output  1  downstream D ready
- d_opcode_in, d_param_in, d_size_in, d_sink_in, d_data_in, d_error_in  input  as crossbar  D response
- d_source_in  input  1  destination master index
- m{0,1}_d_valid  output  1 each  routed D valid
- m{0,1}_d_ready  input  1 each  master D ready
- m_d_opcode, _param, _size, _sink, _data, _error  output  shared D payload (pass-through of d_*_in)
- err_unexp_d  output  1  sticky: D response for a master with zero outstanding

Behaviour:
- **Reset.** Reset (`reset` == 0 at a clk edge) is synchronous. It forces:
  - state IDLE, rr_pri=0;
  - cnt0 = cnt1 = 0;
  - err_unexp_d = 0.
  - Consequently `a_valid_out` = 0, `m*_a_ready` = 0, and all `a_*_out` payload = 0 while in IDLE.
  - Reset mid-transfer abandons the grant. Responses arriving after reset count as unexpected.
- **FSM states.** IDLE, GNT0, GNT1.
- **Eligibility.** Master X is eligible when `mX_a_valid` && cntX < MAX_OUTST.
- **IDLE transitions.**
  - Both eligible: go to GNT[rr_pri].
  - One eligible: go to its GNT.
  - None eligible: stay in IDLE.
  - The grant decision is registered, so there is one bubble cycle per request. Peak throughput is one beat every 2 cycles.
- **GNTX outputs.**
  - `a_valid_out` = `mX_a_valid`.
  - `a_*_out` = master X fields; `a_source_out` = X.
  - `mX_a_ready` = `a_ready_out`; the other master's ready = 0.
- **GNTX transitions.**
  - Handshake (`a_valid_out` && `a_ready_out`): go to IDLE, rr_pri <= ~X, cntX increments.
  - If `mX_a_valid` drops without a handshake (protocol violation): go to IDLE, rr_pri unchanged.
- **Grant lock.** The grant is never switched while `a_valid_out` = 1 and unaccepted.
- **D routing.** Fully combinational, zero latency.
  - `mX_d_valid` = `d_valid_in` && (`d_source_in` == X).
  - `d_ready_in` = `d_source_in` ? `m1_d_ready` : `m0_d_ready`.
  - D payload fans out to both masters unchanged.
- **D fire.** D fire for X is `d_valid_in` && `d_ready_in` && `d_source_in` == X.
  - On D fire with cntX > 0: cntX decrements.
  - On D fire with cntX == 0: cntX stays 0 (no underflow) and err_unexp_d sets. It stays set until reset.
- **Counter arithmetic.**
  - A handshake and D fire for the same master in the same cycle: cntX unchanged.
  - cntX never exceeds MAX_OUTST, because eligibility is checked before the grant.

Test Plan:
- **Single master.** m0 issues Get addr 0x100; a_ready_out=1.
  - `a_valid_out` rises 1 cycle after `m0_a_valid` with a_source_out=0.
  - cnt0=1; D with d_source_in=0 asserts only `m0_d_valid`; cnt0 returns to 0.
- **Contention round-robin.** m0 and m1 both hold valid continuously; a_ready_out=1.
  - Grants alternate 0,1,0,1 starting with 0 after reset, one beat every 2 cycles.
- **Backpressure hold.** Grant m1, a_ready_out=0 for 5 cycles while m0 is also valid.
  - `a_out` stays on m1 with payload stable.
  - `m0_a_ready`=0 throughout; m1 is accepted on the cycle a_ready_out=1.
- **Outstanding limit.** MAX_OUTST=4, no D responses; m0 issues 5 requests.
  - 4 are accepted; the 5th is not granted.
  - One D to m0 lets the 5th be granted next IDLE evaluation.
  - Simultaneous A handshake and D on m0 keeps cnt0 constant.
- **Unexpected D and D backpressure.**
  - D with d_source_in=1 while cnt1=0: err_unexp_d=1 next cycle and sticky; cnt1 stays 0.
  - m1_d_ready=0 gives d_ready_in=0.
- **Reset mid-operation.** Assert reset during GNT0 with a_ready_out=0.
  - Next cycle: `a_valid_out`=0, counters 0, rr_pri=0, err cleared.
